motion_bbox_detect: RTL and testbench

Consumes the eroded binary pixel stream (vsync/href/clken/bit) at the tail of the frame-difference motion path and reports, once per frame, the bounding box and population of foreground pixels. It is the reader for the morphology filters' output stream. Its results feed the rectangle-overlay and host-readout logic downstream. An optional noise floor suppresses detection when too few pixels are set.

---
 rtl/motion_pkg.sv | 26 ++
 rtl/stream_pos_counter.sv | 112 +++++++++++
 rtl/motion_bbox_detect.sv | 189 ++++++++++++++++++
 tb/tb_motion_bbox_detect.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
`default_nettype none
// ============================================================================
// Module   : motion_pkg
// Purpose  : Shared widths and FSM encoding for the motion bounding-box
//            detector (motion_bbox_detect and stream_pos_counter).
// Contents : X_W / Y_W   - column / line counter widths
//            CNT_W       - foreground population counter width
//            bbox_state_t- frame-tracking FSM states
// Revision : 1.0 - initial release
// ============================================================================
package motion_pkg;

  localparam int X_W   = 10;
  localparam int Y_W   = 10;
  localparam int CNT_W = 19;

  // Frame tracking: idle until a frame starts, collect while the frame is
  // active, then spend exactly one cycle publishing the results.
  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    REPORT   = 2'd2
  } bbox_state_t;

endpackage : motion_pkg
`default_nettype wire

// File: rtl/stream_pos_counter.sv
`default_nettype none
// ============================================================================
// Module   : stream_pos_counter
// Purpose  : Registers the binary pixel stream once, detects frame / line
//            edges on the registered copy and tracks the (x, y) position of
//            the current pixel with saturating counters.
// Ports    : clk, rst_n          - pixel clock, async active-low reset
//            vsync, href, clken  - raw stream framing / strobe inputs
//            pix_in              - raw foreground bit
//            pix_accept          - registered vsync & href & clken
//            pix_bit             - registered foreground bit
//            x, y                - position of the pixel presented this cycle
//            sof, eof            - one-cycle vsync rise / fall strobes
// Revision : 1.0 - initial release
// ============================================================================
module stream_pos_counter
  import motion_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           vsync,
  input  logic           href,
  input  logic           clken,
  input  logic           pix_in,
  output logic           pix_accept,
  output logic           pix_bit,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           sof,
  output logic           eof
);

  localparam logic [X_W-1:0] c_X_MAX = '1;
  localparam logic [Y_W-1:0] c_Y_MAX = '1;

  logic           r_vsync;
  logic           r_href;
  logic           r_clken;
  logic           r_bit;
  logic           r_vsync_d;
  logic           r_href_d;
  logic [1:0]     r_prime;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;

  logic           w_hist_ok;
  logic           w_href_fall;

  // --------------------------------------------------------------------------
  // Input register plus one-deep history for edge detection.
  // r_prime fills with ones one edge at a time: r_prime[1] is set once both
  // r_vsync and r_vsync_d hold genuine samples. Without this, a reset
  // released while vsync is already high would look like a rising edge and
  // start collecting a partial frame.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync   <= 1'b0;
      r_href    <= 1'b0;
      r_clken   <= 1'b0;
      r_bit     <= 1'b0;
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
      r_prime   <= 2'b00;
    end else begin
      r_vsync   <= vsync;
      r_href    <= href;
      r_clken   <= clken;
      r_bit     <= pix_in;
      r_vsync_d <= r_vsync;
      r_href_d  <= r_href;
      r_prime   <= {r_prime[0], 1'b1};
    end
  end

  assign w_hist_ok   = r_prime[1];
  assign sof         = w_hist_ok &  r_vsync & ~r_vsync_d;
  assign eof         = w_hist_ok & ~r_vsync &  r_vsync_d;
  assign w_href_fall = ~r_href & r_href_d;
  assign pix_accept  = r_vsync & r_href & r_clken;
  assign pix_bit     = r_bit;

  // --------------------------------------------------------------------------
  // Position counters. x/y describe the pixel currently presented on
  // pix_accept; they advance on the same edge the consumer samples them.
  // Both stick at all-ones so overlong lines / frames cannot wrap back into
  // the active window.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (sof) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_href_fall) begin
      // href low means no pixel is accepted this cycle, so the line end has
      // priority over the x increment without losing anything.
      r_x <= '0;
      if (r_y != c_Y_MAX) begin
        r_y <= r_y + 1'b1;
      end
    end else if (pix_accept && (r_x != c_X_MAX)) begin
      r_x <= r_x + 1'b1;
    end
  end

  assign x = r_x;
  assign y = r_y;

endmodule : stream_pos_counter
`default_nettype wire

// File: rtl/motion_bbox_detect.sv
`default_nettype none
// ============================================================================
// Module   : motion_bbox_detect
// Purpose  : Reduces the eroded binary motion stream to one bounding box and
//            foreground population per frame. Results are published with a
//            one-cycle bbox_valid pulse and held until the next frame.
// Params   : IMG_HDISP  - active pixels per line
//            IMG_VDISP  - active lines per frame
//            MIN_PIXELS - minimum foreground count for a valid detection
// Ports    : clk, rst_n                     - pixel clock, async active-low
//            erosion_vsync/href/clken       - stream framing and strobe
//            erosion_img_Bit                - foreground bit (1 = motion)
//            bbox_valid                     - results-updated pulse
//            bbox_detected                  - enough foreground last frame
//            bbox_x_min/x_max/y_min/y_max   - inclusive bounds (0 if none)
//            pixel_count                    - saturating foreground count
// Revision : 1.0 - initial release
// ============================================================================
module motion_bbox_detect
  import motion_pkg::*;
#(
  parameter logic [X_W-1:0]   IMG_HDISP  = 10'd640,
  parameter logic [Y_W-1:0]   IMG_VDISP  = 10'd480,
  parameter logic [CNT_W-1:0] MIN_PIXELS = 19'd16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             erosion_vsync,
  input  logic             erosion_href,
  input  logic             erosion_clken,
  input  logic             erosion_img_Bit,
  output logic             bbox_valid,
  output logic             bbox_detected,
  output logic [X_W-1:0]   bbox_x_min,
  output logic [X_W-1:0]   bbox_x_max,
  output logic [Y_W-1:0]   bbox_y_min,
  output logic [Y_W-1:0]   bbox_y_max,
  output logic [CNT_W-1:0] pixel_count
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [X_W-1:0]   c_X_INIT  = IMG_HDISP - 1'b1;
  localparam logic [Y_W-1:0]   c_Y_INIT  = IMG_VDISP - 1'b1;

  // Stream position interface
  logic           w_pix_accept;
  logic           w_pix_bit;
  logic [X_W-1:0] w_x;
  logic [Y_W-1:0] w_y;
  logic           w_sof;
  logic           w_eof;

  // FSM
  bbox_state_t    r_state;
  bbox_state_t    w_state_next;
  logic           w_acc_clear;
  logic           w_acc_en;
  logic           w_report;

  // Accumulators
  logic [X_W-1:0]   r_x_min;
  logic [X_W-1:0]   r_x_max;
  logic [Y_W-1:0]   r_y_min;
  logic [Y_W-1:0]   r_y_max;
  logic [CNT_W-1:0] r_count;
  logic             r_any;

  logic             w_in_range;
  logic             w_detected;

  stream_pos_counter u_pos (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (erosion_vsync),
    .href       (erosion_href),
    .clken      (erosion_clken),
    .pix_in     (erosion_img_Bit),
    .pix_accept (w_pix_accept),
    .pix_bit    (w_pix_bit),
    .x          (w_x),
    .y          (w_y),
    .sof        (w_sof),
    .eof        (w_eof)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_SOF;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. An eof seen outside ACTIVE belongs to a frame
  // whose start was never observed (e.g. reset mid-frame) and is dropped.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WAIT_SOF: if (w_sof) w_state_next = ACTIVE;
      ACTIVE:   if (w_eof) w_state_next = REPORT;
      REPORT:   w_state_next = WAIT_SOF;
      default:  w_state_next = WAIT_SOF;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode
  // --------------------------------------------------------------------------
  assign w_in_range = (w_x < IMG_HDISP) && (w_y < IMG_VDISP);

  always_comb begin
    w_acc_clear = 1'b0;
    w_acc_en    = 1'b0;
    w_report    = 1'b0;
    case (r_state)
      WAIT_SOF: w_acc_clear = w_sof;
      ACTIVE:   w_acc_en    = w_pix_accept & w_pix_bit & w_in_range;
      REPORT:   w_report    = 1'b1;
      default:  ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Bounding-box and population accumulators. Min registers start at the
  // far edge so the first foreground pixel always replaces them.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_min <= c_X_INIT;
      r_x_max <= '0;
      r_y_min <= c_Y_INIT;
      r_y_max <= '0;
      r_count <= '0;
      r_any   <= 1'b0;
    end else if (w_acc_clear) begin
      r_x_min <= c_X_INIT;
      r_x_max <= '0;
      r_y_min <= c_Y_INIT;
      r_y_max <= '0;
      r_count <= '0;
      r_any   <= 1'b0;
    end else if (w_acc_en) begin
      if (w_x < r_x_min) r_x_min <= w_x;
      if (w_x > r_x_max) r_x_max <= w_x;
      if (w_y < r_y_min) r_y_min <= w_y;
      if (w_y > r_y_max) r_y_max <= w_y;
      if (r_count != c_CNT_MAX) begin
        r_count <= r_count + 1'b1;
      end
      r_any <= 1'b1;
    end
  end

  // r_any guards the MIN_PIXELS == 0 case, where the count test alone would
  // report a box built from the untouched initial min/max values.
  assign w_detected = r_any && (r_count >= MIN_PIXELS);

  // --------------------------------------------------------------------------
  // Output registers: loaded only in REPORT, held otherwise.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bbox_valid    <= 1'b0;
      bbox_detected <= 1'b0;
      bbox_x_min    <= '0;
      bbox_x_max    <= '0;
      bbox_y_min    <= '0;
      bbox_y_max    <= '0;
      pixel_count   <= '0;
    end else begin
      bbox_valid <= w_report;
      if (w_report) begin
        bbox_detected <= w_detected;
        bbox_x_min    <= w_detected ? r_x_min : '0;
        bbox_x_max    <= w_detected ? r_x_max : '0;
        bbox_y_min    <= w_detected ? r_y_min : '0;
        bbox_y_max    <= w_detected ? r_y_max : '0;
        pixel_count   <= r_count;
      end
    end
  end

endmodule : motion_bbox_detect
`default_nettype wire

// File: tb/tb_motion_bbox_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_motion_bbox_detect
// Purpose  : Self-checking bench for motion_bbox_detect. Two instances share
//            one stimulus stream and differ only in MIN_PIXELS. Frames are
//            described as per-line pixel counts plus a set of foreground
//            coordinates; a frame-level model derives the expected report.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motion_bbox_detect;

  localparam int HD   = 640;
  localparam int VD   = 480;
  localparam int MIN1 = 16;
  localparam int MIN2 = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic vs    = 1'b0;
  logic hs    = 1'b0;
  logic ce    = 1'b0;
  logic bt    = 1'b0;

  logic        v1, d1, v2, d2;
  logic [9:0]  xa1, xb1, ya1, yb1, xa2, xb2, ya2, yb2;
  logic [18:0] c1, c2;

  always #5 clk = ~clk;

  motion_bbox_detect #(.IMG_HDISP(10'd640), .IMG_VDISP(10'd480), .MIN_PIXELS(19'd16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .erosion_vsync(vs), .erosion_href(hs),
    .erosion_clken(ce), .erosion_img_Bit(bt), .bbox_valid(v1), .bbox_detected(d1),
    .bbox_x_min(xa1), .bbox_x_max(xb1), .bbox_y_min(ya1), .bbox_y_max(yb1),
    .pixel_count(c1)
  );

  motion_bbox_detect #(.IMG_HDISP(10'd640), .IMG_VDISP(10'd480), .MIN_PIXELS(19'd2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .erosion_vsync(vs), .erosion_href(hs),
    .erosion_clken(ce), .erosion_img_Bit(bt), .bbox_valid(v2), .bbox_detected(d2),
    .bbox_x_min(xa2), .bbox_x_max(xb2), .bbox_y_min(ya2), .bbox_y_max(yb2),
    .pixel_count(c2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int cnt;
    int xmn;
    int xmx;
    int ymn;
    int ymx;
  } res_t;

  res_t pend[$];       // reports the DUTs owe, tagged with the pulse cycle
  int   line_len[$];   // clken strobes per line of the frame being built
  bit   fg[int];       // foreground set, key = y*4096 + x
  bit   mon_on = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: walk the described pixels, keep those inside the
  // active window, and fold them into count / extremes.
  function automatic res_t model_frame();
    res_t r;
    r.cyc = 0; r.cnt = 0;
    r.xmn = HD - 1; r.xmx = 0; r.ymn = VD - 1; r.ymx = 0;
    for (int y = 0; y < line_len.size(); y++) begin
      for (int x = 0; x < line_len[y]; x++) begin
        if (fg.exists(y * 4096 + x) && x < HD && y < VD) begin
          r.cnt++;
          if (x < r.xmn) r.xmn = x;
          if (x > r.xmx) r.xmx = x;
          if (y < r.ymn) r.ymn = y;
          if (y > r.ymx) r.ymx = y;
        end
      end
    end
    return r;
  endfunction

  task automatic check_dut(input string nm, input logic v, input logic d,
                           input logic [9:0] xa, input logic [9:0] xb,
                           input logic [9:0] ya, input logic [9:0] yb,
                           input logic [18:0] c, input res_t r,
                           input int minp, input bit ev);
    bit det;
    logic [59:0] act_v, exp_v;
    det = (r.cnt >= minp) && (r.cnt > 0);
    act_v = {d, xa, xb, ya, yb, c};
    exp_v = {det, det ? 10'(r.xmn) : 10'd0, det ? 10'(r.xmx) : 10'd0,
             det ? 10'(r.ymn) : 10'd0, det ? 10'(r.ymx) : 10'd0, 19'(r.cnt)};
    chk({nm, "_valid"}, v, ev);
    if (ev) begin
      chk({nm, "_detected"}, d, det);
      chk({nm, "_x_min"}, xa, exp_v[58:49]);
      chk({nm, "_x_max"}, xb, exp_v[48:39]);
      chk({nm, "_y_min"}, ya, exp_v[38:29]);
      chk({nm, "_y_max"}, yb, exp_v[28:19]);
      chk({nm, "_count"}, c, exp_v[18:0]);
    end else begin
      chk({nm, "_hold"}, act_v, exp_v);
    end
  endtask

  // Single compare process: every cycle, both instances against the model.
  res_t last;
  bit   ev;
  initial last = '{default: 0};
  always @(negedge clk) begin
    if (mon_on) begin
      ev = 1'b0;
      if (!rst_n) begin
        last = '{default: 0};
      end else if (pend.size() > 0 && pend[0].cyc == cyc) begin
        last = pend.pop_front();
        ev   = 1'b1;
      end
      check_dut("dut1", v1, d1, xa1, xb1, ya1, yb1, c1, last, MIN1, ev);
      check_dut("dut2", v2, d2, xa2, xb2, ya2, yb2, c2, last, MIN2, ev);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // tail_mode: 0 = href drops, then vsync drops
  //            1 = href and vsync drop in the same sample
  //            2 = vsync drops while a strobed foreground pixel is presented
  // rst_line : line before which reset is pulsed (frame then not reported)
  task automatic drive_frame(input int tail_mode, input int rst_line,
                             input int gap_pct, output res_t m);
    int nl;
    res_t r;
    nl = line_len.size();
    hs = 1'b0; ce = 1'b0; bt = 1'b0; vs = 1'b0;
    repeat (3) step();
    vs = 1'b1;
    repeat (1 + $urandom_range(0, 2)) step();
    for (int y = 0; y < nl; y++) begin
      if (y == rst_line) begin
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
      end
      hs = 1'b1; ce = 1'b0; bt = 1'b0;
      step();
      for (int x = 0; x < line_len[y]; x++) begin
        if ($urandom_range(0, 99) < gap_pct) begin
          ce = 1'b0; bt = 1'($urandom_range(0, 1));
          step();
        end
        ce = 1'b1; bt = fg.exists(y * 4096 + x);
        step();
      end
      ce = 1'b0; bt = 1'b0;
      if (!(tail_mode == 1 && y == nl - 1)) begin
        hs = 1'b0;
        repeat (1 + $urandom_range(0, 2)) step();
      end
    end
    if (tail_mode == 2) begin
      hs = 1'b1; ce = 1'b1; bt = 1'b1;
    end else begin
      hs = 1'b0;
    end
    vs = 1'b0;
    r = model_frame();
    m = r;
    if (rst_line < 0) begin
      r.cyc = cyc + 3;
      pend.push_back(r);
    end
    step();
    hs = 1'b0; ce = 1'b0; bt = 1'b0;
    repeat (6) step();
  endtask

  task automatic build_random(input int max_lines, input int max_len);
    int nl, dens, l;
    nl   = $urandom_range(0, max_lines);
    dens = $urandom_range(0, 60);
    line_len.delete();
    fg.delete();
    for (int y = 0; y < nl; y++) begin
      l = $urandom_range(0, max_len);
      line_len.push_back(l);
      for (int x = 0; x < l; x++)
        if ($urandom_range(0, 99) < dens) fg[y * 4096 + x] = 1'b1;
    end
  endtask

  res_t m;

  initial begin
    #2 rst_n = 1'b0;
    mon_on = 1'b1;
    repeat (3) step();
    chk("reset_valid", v1, 0);
    chk("reset_detected", d1, 0);
    chk("reset_count", c1, 0);
    chk("reset_x_max", xb1, 0);
    rst_n = 1'b1;
    repeat (3) step();

    // Block of motion at x=100..119, y=50..59.
    line_len.delete(); fg.delete();
    for (int y = 0; y < 80; y++) line_len.push_back((y >= 50 && y < 60) ? 120 : $urandom_range(0, 4));
    for (int y = 50; y < 60; y++) for (int x = 100; x < 120; x++) fg[y * 4096 + x] = 1'b1;
    drive_frame(0, -1, 20, m);
    chk("model_f1_count", m.cnt, 200);
    chk("model_f1_x_min", m.xmn, 100);
    chk("model_f1_x_max", m.xmx, 119);
    chk("model_f1_y_min", m.ymn, 50);
    chk("model_f1_y_max", m.ymx, 59);
    chk("f1_dut1_x_min", xa1, 100);
    chk("f1_dut1_y_max", yb1, 59);
    chk("f1_dut1_count", c1, 200);
    chk("f1_dut1_detected", d1, 1);

    // All-zero frame.
    line_len.delete(); fg.delete();
    for (int y = 0; y < 20; y++) line_len.push_back(30);
    drive_frame(1, -1, 10, m);
    chk("model_f2_count", m.cnt, 0);
    chk("f2_dut1_x_max", xb1, 0);

    // Opposite corners only.
    line_len.delete(); fg.delete();
    line_len.push_back(1);
    for (int y = 1; y < 479; y++) line_len.push_back(0);
    line_len.push_back(640);
    fg[0] = 1'b1;
    fg[479 * 4096 + 639] = 1'b1;
    drive_frame(0, -1, 0, m);
    chk("model_f3_count", m.cnt, 2);
    chk("model_f3_x_max", m.xmx, 639);
    chk("model_f3_y_max", m.ymx, 479);
    chk("f3_dut2_detected", d2, 1);
    chk("f3_dut2_x_max", xb2, 639);
    chk("f3_dut2_y_max", yb2, 479);
    chk("f3_dut1_detected", d1, 0);
    chk("f3_dut1_count", c1, 2);

    // 15 scattered ones: below 16, above 2.
    line_len.delete(); fg.delete();
    for (int y = 0; y < 20; y++) line_len.push_back(40);
    for (int i = 0; i < 15; i++) fg[i * 4096 + (i * 7 + 3) % 40] = 1'b1;
    drive_frame(2, -1, 15, m);
    chk("model_f4_count", m.cnt, 15);
    chk("f4_dut1_count", c1, 15);
    chk("f4_dut1_detected", d1, 0);

    // Ones only outside the active window (x>=640 on line 0, line 480).
    line_len.delete(); fg.delete();
    line_len.push_back(650);
    for (int y = 1; y < 480; y++) line_len.push_back(0);
    line_len.push_back(10);
    for (int x = 640; x < 650; x++) fg[x] = 1'b1;
    for (int x = 0; x < 10; x++) fg[480 * 4096 + x] = 1'b1;
    drive_frame(1, -1, 0, m);
    chk("model_f5_count", m.cnt, 0);
    chk("f5_dut2_detected", d2, 0);

    // Zero-line frame still reports.
    line_len.delete(); fg.delete();
    drive_frame(0, -1, 0, m);
    chk("model_f6_count", m.cnt, 0);

    // Reset after 5000 foreground pixels, released with vsync high.
    line_len.delete(); fg.delete();
    for (int y = 0; y < 60; y++) begin
      line_len.push_back(100);
      for (int x = 0; x < 100; x++) fg[y * 4096 + x] = 1'b1;
    end
    drive_frame(0, 50, 0, m);

    // Random frames, including a few wide lines straddling x=640.
    build_random(25, 70);
    drive_frame(0, -1, 10, m);
    build_random(3, 680);
    drive_frame(0, -1, 5, m);
    for (int f = 0; f < 10; f++) begin
      build_random(25, 70);
      drive_frame($urandom_range(0, 2), -1, $urandom_range(0, 30), m);
    end

    repeat (10) step();
    chk("pending_reports", pend.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_motion_bbox_detect
`default_nettype wire
